// File: rtl/step_input_conditioner_pkg.sv
// Shared defaults and helpers for the step input conditioner.
// Counter widths are derived here so every instance sizes them the same way.
package step_cond_pkg;

    localparam int DEF_SW_W            = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STEP_PERIOD     = 1000;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [1:0] {
        STEP_NONE   = 2'd0,
        STEP_MANUAL = 2'd1,
        STEP_AUTO   = 2'd2
    } step_src_e;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            cnt_width = 1;
        end else begin
            cnt_width = $clog2(n);
        end
    endfunction

endpackage

// File: rtl/step_input_conditioner_debounce_bit.sv
// One-bit two-flop synchroniser followed by a persistence-count debouncer.
// The debounced level moves only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit
    import step_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int              DB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic [DB_W-1:0] cnt_r;
    logic            level_next_s;
    logic [DB_W-1:0] cnt_next_s;

    // Persistence counter: any agreeing sample restarts the count.
    always_comb begin
        level_next_s = level_r;
        cnt_next_s   = cnt_r;
        if (sync2_r == level_r) begin
            cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            level_next_s = sync2_r;
            cnt_next_s   = CNT_ZERO;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            level_r <= level_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/step_input_conditioner.sv
// Board-input front end: debounced switch word plus a one-cycle step strobe,
// sourced either from the step button (manual) or a fixed-period timer (auto-run).
module step_input_conditioner
    import step_cond_pkg::*;
#(
    parameter int SW_W            = DEF_SW_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_PERIOD     = DEF_STEP_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic             btn_raw,
    input  logic             run_en,
    output logic [SW_W-1:0]  sw_out,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count
);

    localparam int               PER_W    = cnt_width(STEP_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);
    localparam logic [PER_W-1:0] PER_ZERO = {PER_W{1'b0}};
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SW_W-1:0]  sw_level_s;
    logic             btn_level_s;
    logic             btn_prev_r;
    logic [PER_W-1:0] period_r;
    logic [SW_W-1:0]  sw_out_r;
    logic             step_pulse_r;
    logic [CNT_W-1:0] step_count_r;

    step_src_e        step_src_s;
    logic             step_next_s;
    logic [PER_W-1:0] period_next_s;
    logic [SW_W-1:0]  sw_next_s;
    logic [CNT_W-1:0] count_next_s;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .level (sw_level_s[i])
        );
    end

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw),
        .level (btn_level_s)
    );

    // Strobe source selection, period timer and switch-word deferral.
    always_comb begin
        step_src_s = STEP_NONE;
        if (step_pulse_r) begin
            // A strobe is never followed directly by another one.
            step_src_s = STEP_NONE;
        end else if (run_en) begin
            if (period_r == PER_LAST) begin
                step_src_s = STEP_AUTO;
            end else begin
                step_src_s = STEP_NONE;
            end
        end else if (btn_level_s && !btn_prev_r) begin
            step_src_s = STEP_MANUAL;
        end else begin
            step_src_s = STEP_NONE;
        end

        step_next_s = (step_src_s != STEP_NONE);

        period_next_s = PER_ZERO;
        if (!run_en) begin
            period_next_s = PER_ZERO;
        end else if (period_r == PER_LAST) begin
            period_next_s = PER_ZERO;
        end else begin
            period_next_s = period_r + PER_ONE;
        end

        // Hold the word on the edge that raises the strobe so downstream sees it stable.
        sw_next_s = sw_level_s;
        if (step_next_s) begin
            sw_next_s = sw_out_r;
        end else begin
            sw_next_s = sw_level_s;
        end

        count_next_s = step_count_r;
        if (step_pulse_r) begin
            count_next_s = step_count_r + CNT_ONE;
        end else begin
            count_next_s = step_count_r;
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev_r   <= 1'b0;
            period_r     <= PER_ZERO;
            sw_out_r     <= {SW_W{1'b0}};
            step_pulse_r <= 1'b0;
            step_count_r <= {CNT_W{1'b0}};
        end else begin
            btn_prev_r   <= btn_level_s;
            period_r     <= period_next_s;
            sw_out_r     <= sw_next_s;
            step_pulse_r <= step_next_s;
            step_count_r <= count_next_s;
        end
    end

    assign sw_out     = sw_out_r;
    assign step_pulse = step_pulse_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_step_input_conditioner.sv
// Scoreboard bench for step_input_conditioner with short debounce and period.
// Stimulus queues each expected strobe; a monitor pops and checks it when step_pulse rises.
module tb_step_input_conditioner;

    localparam int SW_W = 2;
    localparam int DB   = 4;
    localparam int PER  = 8;
    localparam int CW   = 4;

    typedef struct {
        int         cyc;
        logic [1:0] sw;
        int         cnt;
    } strobe_t;

    logic            clk;
    logic            reset;
    logic [SW_W-1:0] sw_raw;
    logic            btn_raw;
    logic            run_en;
    logic [SW_W-1:0] sw_out;
    logic            step_pulse;
    logic [CW-1:0]   step_count;

    int      cyc;
    int      n_vec;
    int      n_err;
    int      c;
    strobe_t exp_q[$];

    step_input_conditioner #(
        .SW_W(SW_W), .DEBOUNCE_CYCLES(DB), .STEP_PERIOD(PER), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .run_en     (run_en),
        .sw_out     (sw_out),
        .step_pulse (step_pulse),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input logic [1:0] sw, input int cnt);
        strobe_t e;
        e.cyc = at;
        e.sw  = sw;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL strobe_unexpected: got strobe at cycle %0d, expected none", cyc);
            end else begin
                strobe_t e;
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_sw_out", int'(sw_out), int'(e.sw));
                check("strobe_count", int'(step_count), e.cnt);
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        sw_raw  = 2'b11;
        btn_raw = 1'b1;
        run_en  = 1'b1;
        step(3);
        check("rst_sw_out", int'(sw_out), 0);
        check("rst_step_pulse", int'(step_pulse), 0);
        check("rst_step_count", int'(step_count), 0);

        // Release: raw levels already stable, so the word appears 7 edges later.
        reset = 1'b1;
        step(6);
        check("sw_out_before_latency", int'(sw_out), 0);
        step(1);
        check("sw_out_at_latency", int'(sw_out), 3);
        run_en = 1'b0;
        step(10);
        check("no_strobe_on_manual_entry", int'(step_count), 0);

        btn_raw = 1'b0;
        sw_raw  = 2'b01;
        step(10);
        check("sw_out_01", int'(sw_out), 1);

        // Bounce: 2-cycle pulses are too short, the final steady press counts once.
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            step(1);
        end
        btn_raw = 1'b1;
        push(cyc + 7, 2'b01, 0);
        step(12);
        check("bounce_count", int'(step_count), 1);

        // Manual hold then release.
        btn_raw = 1'b0;
        step(10);
        btn_raw = 1'b1;
        push(cyc + 7, 2'b01, 1);
        step(50);
        btn_raw = 1'b0;
        step(10);
        check("hold_count", int'(step_count), 2);

        // Auto-run for 44 cycles: five strobes on multiples of the period.
        run_en = 1'b1;
        c = cyc;
        for (int k = 1; k <= 5; k++) push(c + 8 * k, 2'b01, 1 + k);
        step(44);
        run_en = 1'b0;
        step(20);
        check("auto_count", int'(step_count), 7);

        // Collision: debounced 01->10 lands on the strobe edge and is held one cycle.
        run_en = 1'b1;
        c = cyc;
        push(c + 8, 2'b01, 7);
        step(1);
        sw_raw = 2'b10;
        step(8);
        check("collision_sw_after", int'(sw_out), 2);
        run_en = 1'b0;
        step(4);
        check("collision_count", int'(step_count), 8);

        // Wrap: nine more strobes bring the 4-bit counter to 17 mod 16.
        run_en = 1'b1;
        c = cyc;
        for (int k = 1; k <= 10; k++) push(c + 8 * k, 2'b10, (7 + k) % 16);
        step(73);
        check("wrap_count", int'(step_count), 1);
        step(7);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_strobe_pulse", int'(step_pulse), 0);
        check("rst_mid_strobe_count", int'(step_count), 0);
        check("rst_mid_strobe_sw_out", int'(sw_out), 0);
        run_en = 1'b0;
        step(2);
        reset = 1'b1;
        step(10);
        check("missing_strobes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
